// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared constants and FSM state type for the RV32I register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

   // Default datapath width for RV32I
   localparam int XLEN_DEFAULT = 32;

   // Architectural zero register address
   localparam int REG_ZERO = 0;

   // Register-file FSM: hardware clear after reset, then normal operation
   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
// Module   : regfile_rdport
// Purpose  : One combinational read port: x0 mask, zero while clearing, and
//            an optional same-cycle write bypass (macro REGFILE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rdport
   import rv_pkg::*;
#(
   parameter  int XLEN = XLEN_DEFAULT,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] regs [NREG],
   input  logic            run,
   input  logic            we,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] wd3,
   output logic [XLEN-1:0] rd
);

`ifdef REGFILE_BYPASS_EN
   // Read mux: zero for x0 or while clearing, forward pending write data, else storage
   always_comb begin
      rd = '0;
      if (run && addr != AW'(REG_ZERO)) begin
         if (we && a3 != AW'(REG_ZERO) && a3 == addr) begin
            rd = wd3;
         end else begin
            rd = regs[addr];
         end
      end
   end
`else
   // Write-port signals only feed the forwarding path, which is absent here
   logic unused_bypass;
   assign unused_bypass = ^{we, a3, wd3};

   // Read mux: zero for x0 or while clearing, else storage
   always_comb begin
      rd = '0;
      if (run && addr != AW'(REG_ZERO)) begin
         rd = regs[addr];
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-read-port integer register file. x0 is
//            hardwired to zero; reset starts a sequential clear of every
//            register before ready is raised. Optional write-to-read bypass
//            is enabled by defining REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
   import rv_pkg::*;
#(
   parameter  int XLEN = XLEN_DEFAULT,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [AW-1:0]       a3,
   input  logic [XLEN-1:0]     wd3,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic                ready
);

   rf_state_t       state;
   logic [AW-1:0]   clr_idx;
   logic            run;

   // x0 has no storage; entries start at index 1
   logic [XLEN-1:0] mem  [1:NREG-1];
   // Read view of the whole file with a constant-zero slot for x0
   logic [XLEN-1:0] view [NREG];

   assign run = (state == RF_RUN);

   // FSM: walk clr_idx through every register, then stay in RUN until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RF_CLEAR;
         clr_idx <= AW'(1);
         ready   <= 1'b0;
      end else begin
         case (state)
            RF_CLEAR: begin
               if (clr_idx == AW'(NREG-1)) begin
                  state <= RF_RUN;
                  ready <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            RF_RUN: begin
               state <= RF_RUN;
            end
            default: begin
               state   <= RF_CLEAR;
               clr_idx <= AW'(1);
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Storage: clear writes zero while clearing (user writes dropped), else normal write port
   always_ff @(posedge clk) begin
      if (state == RF_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (we && a3 != AW'(REG_ZERO)) begin
         mem[a3] <= wd3;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_view
      if (g == REG_ZERO) begin : g_zero
         assign view[g] = '0;
      end else begin : g_reg
         assign view[g] = mem[g];
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rdport
      regfile_rdport #(
         .XLEN (XLEN),
         .NREG (NREG)
      ) u_rdport (
         .addr (ra[p*AW +: AW]),
         .regs (view),
         .run  (run),
         .we   (we),
         .a3   (a3),
         .wd3  (wd3),
         .rd   (rd[p*XLEN +: XLEN])
      );
   end

endmodule

`default_nettype wire
